port_tx_serializer: RTL and testbench
=====================================

// Module: port_tx_serializer
// PURPOSE
//  Output-port serializer downstream of the MCU controller's 16-bit portOut.
//  Each controller port write (port_we) pushes one 16-bit word into a small FIFO.
//  A UART-style 8N1 transmitter drains the FIFO and sends every word as two frames,
//  low byte first. Bytes go LSB first on tx. Transmission does not stall the core.
// PARAMETERS
//  DATA_W        16  port word width; fixed at 16 (two 8-bit frames per word)
//  DEPTH         4   FIFO depth in words; power of two, >= 2
//  CLKS_PER_BIT  16  clk cycles per serial bit; >= 2
// PORTS
//  clk        in   1       system clock; all state changes on posedge
//  rst        in   1       asynchronous, active-low reset
//  port_data  in   16      word driven by controller portOut
//  port_we    in   1       1-cycle write strobe; samples port_data at posedge
//  ovf_clr    in   1       clears sticky overflow flag
//  tx         out  1       serial output, idle high
//  busy       out  1       1 while the transmitter is not in IDLE
//  empty      out  1       FIFO holds no words
//  full       out  1       FIFO holds DEPTH words
//  count      out  clog2(DEPTH+1)  words currently stored
//  overflow   out  1       sticky: a write was dropped because the FIFO was full
// BEHAVIOUR
//  Reset (rst=0, async): tx=1, busy=0, empty=1, full=0, count=0, overflow=0.
//   FIFO pointers are cleared and the FSM goes to IDLE immediately, mid-frame included.
//   The frame in flight is abandoned and never resumed.
//  FIFO: circular buffer. Pointers wrap modulo DEPTH. count is exact 0..DEPTH.
//   Push: port_we=1 and (not full, or a pop occurs at the same edge).
//   Pop: the FSM leaves IDLE with empty=0. The word is moved to the shift register.
//   Push and pop at the same edge: both take effect and count is unchanged.
//   Push on full with no pop: the word is dropped, FIFO is unchanged, overflow<=1.
//   ovf_clr and a dropped write at the same edge: set wins, so overflow=1.
//  FSM states: IDLE, START, DATA, STOP. It also tracks bit_idx (0..7), byte_sel
//   (0=low, 1=high) and a baud counter (0..CLKS_PER_BIT-1).
//   IDLE:  tx=1. If !empty: pop, byte_sel<=0, go to START. Otherwise stay in IDLE.
//   START: tx=0 for CLKS_PER_BIT cycles, then go to DATA with bit_idx=0.
//   DATA:  tx=current byte[bit_idx] for CLKS_PER_BIT cycles per bit.
//          After bit 7, go to STOP.
//   STOP:  tx=1 for CLKS_PER_BIT cycles. Then:
//          if byte_sel=0: byte_sel<=1 and go directly to START (no gap);
//          if byte_sel=1: go to IDLE.
//  tx is driven from a register (glitch-free). busy = (state != IDLE).
//  Latency: a push into an empty, idle block at edge N gives the pop at edge N+1.
//   tx falls after edge N+1.
//  Word time: exactly 20*CLKS_PER_BIT cycles. Back-to-back words have exactly one
//   IDLE cycle between them (tx=1).
//  port_data is captured at the push edge. Later changes to portOut do not affect
//   words already queued.
// TESTING
//  T1 (CLKS_PER_BIT=4): after reset, push 0xA55A once.
//   tx low from cycle 1: 0 | 0,1,0,1,1,0,1,0 | 1 | 0 | 1,0,1,0,0,1,0,1 | 1,
//   4 clk per bit. busy=1 for exactly 80 cycles, then empty=1, tx=1.
//  T2: from empty/idle, push 0x0001..0x0006 on 6 consecutive cycles.
//   count=1,1,2,3,4,4. The 6th word is dropped and overflow=1.
//   tx emits words 1..5 in order, with 1 IDLE cycle between words.
//  T3: with overflow=1, assert ovf_clr alone -> overflow=0 at the next edge.
//   Repeat with a dropped write in the same cycle -> overflow stays 1.
//  T4: with the FIFO full, pulse port_we on the exact cycle of the IDLE pop.
//   The write is accepted, count stays at 4, overflow stays 0.
//  T5: pull rst low mid-DATA of the high byte, asynchronously between edges.
//   tx=1, busy=0, count=0 immediately. After release, a new push transmits
//   a clean full frame.
//  T6: change port_data on every cycle after a push. The transmitted word equals
//   the value at the push edge.

Source files
------------

// File: rtl/port_tx_serializer_if.sv
// Port-write and serial-status bundle for port_tx_serializer.
// The controller side is master, the serializer is slave.
interface port_tx_serializer_if #(
  parameter int DEPTH = 4
);
  localparam int CW = $clog2(DEPTH + 1);

  logic [15:0]   port_data;
  logic          port_we;
  logic          ovf_clr;
  logic          tx;
  logic          busy;
  logic          empty;
  logic          full;
  logic [CW-1:0] count;
  logic          overflow;

  modport master (
    output port_data,
    output port_we,
    output ovf_clr,
    input  tx,
    input  busy,
    input  empty,
    input  full,
    input  count,
    input  overflow
  );

  modport slave (
    input  port_data,
    input  port_we,
    input  ovf_clr,
    output tx,
    output busy,
    output empty,
    output full,
    output count,
    output overflow
  );
endinterface

// File: rtl/port_tx_serializer.sv
// Port-word FIFO feeding an 8N1 transmitter;
// each 16-bit word goes out as two frames, low byte first.
module port_tx_serializer #(
  parameter int DATA_W       = 16,
  parameter int DEPTH        = 4,
  parameter int CLKS_PER_BIT = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  port_tx_serializer_if.slave  bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int BW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] FULL_N = CW'(DEPTH);
  localparam logic [BW-1:0] BAUD_END = BW'(CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } state_t;

  state_t            state;
  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic [CW-1:0]     count;
  logic [DATA_W-1:0] shreg;
  logic [2:0]        bit_idx;
  logic              byte_sel;
  logic [BW-1:0]     baud;
  logic              tx_q;
  logic              ovf_q;
  logic              empty;
  logic              full;
  logic              pop;
  logic              push;
  logic              drop;
  logic              baud_end;
  logic [7:0]        cur_byte;

  assign empty    = (count == '0);
  assign full     = (count == FULL_N);
  assign pop      = (state == IDLE) && !empty;
  assign push     = bus.port_we && (!full || pop);
  assign drop     = bus.port_we && !push;
  assign baud_end = (baud == BAUD_END);
  assign cur_byte = byte_sel ? shreg[15:8]
                             : shreg[7:0];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      ovf_q  <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)
        count <= count + 1'b1;
      else if (pop && !push)
        count <= count - 1'b1;
      // a dropped write beats a simultaneous clear
      if (drop)
        ovf_q <= 1'b1;
      else if (bus.ovf_clr)
        ovf_q <= 1'b0;
    end
  end

  // Storage needs no reset; a slot written while full+pop
  // is the one being read, and the read sees the old word.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= bus.port_data;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      tx_q     <= 1'b1;
      shreg    <= '0;
      bit_idx  <= '0;
      byte_sel <= 1'b0;
      baud     <= '0;
    end else begin
      if (state != IDLE)
        baud <= baud_end ? '0 : baud + 1'b1;
      unique case (state)
        IDLE: begin
          tx_q <= 1'b1;
          baud <= '0;
          if (pop) begin
            shreg    <= mem[rd_ptr];
            byte_sel <= 1'b0;
            tx_q     <= 1'b0;
            state    <= START;
          end
        end
        START: begin
          if (baud_end) begin
            bit_idx <= '0;
            tx_q    <= cur_byte[0];
            state   <= DATA;
          end
        end
        DATA: begin
          if (baud_end) begin
            if (bit_idx == 3'd7) begin
              tx_q  <= 1'b1;
              state <= STOP;
            end else begin
              bit_idx <= bit_idx + 3'd1;
              tx_q    <= cur_byte[bit_idx + 3'd1];
            end
          end
        end
        STOP: begin
          if (baud_end) begin
            if (!byte_sel) begin
              byte_sel <= 1'b1;
              tx_q     <= 1'b0;
              state    <= START;
            end else begin
              state <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.tx       = tx_q;
  assign bus.busy     = (state != IDLE);
  assign bus.empty    = empty;
  assign bus.full     = full;
  assign bus.count    = count;
  assign bus.overflow = ovf_q;
endmodule

// File: tb/tb_port_tx_serializer.sv
// Scenario bench for port_tx_serializer against a
// queue-plus-frame-position reference model.
module tb_port_tx_serializer;
  localparam int DEPTH    = 4;
  localparam int CPB      = 4;
  localparam int WORD_CYC = 20 * CPB;
  localparam int LIMIT    = 8 * WORD_CYC;

  logic clk = 1'b0;
  logic rst;
  int   errors = 0;
  int   checks = 0;

  port_tx_serializer_if #(.DEPTH(DEPTH)) bus ();

  port_tx_serializer #(
    .DATA_W      (16),
    .DEPTH       (DEPTH),
    .CLKS_PER_BIT(CPB)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  logic [15:0] m_q[$];
  logic [15:0] m_cur;
  bit          m_busy;
  int          m_pos;
  bit          m_ovf;

  function automatic logic exp_tx();
    int k;
    int b;
    logic [7:0] byt;
    if (!m_busy) return 1'b1;
    k = m_pos / CPB;
    b = k % 10;
    byt = (k < 10) ? m_cur[7:0] : m_cur[15:8];
    if (b == 0) return 1'b0;
    if (b == 9) return 1'b1;
    return byt[b-1];
  endfunction

  function automatic logic [7:0] exp_vec();
    int n;
    n = m_q.size();
    return {exp_tx(), m_busy, n == 0, n == DEPTH,
            m_ovf, 3'(n)};
  endfunction

  function automatic logic [7:0] dut_vec();
    return {bus.tx, bus.busy, bus.empty, bus.full,
            bus.overflow, bus.count};
  endfunction

  task automatic model_reset();
    m_q.delete();
    m_busy = 0;
    m_pos  = 0;
    m_ovf  = 0;
  endtask

  task automatic model_step();
    bit pop;
    bit can;
    pop = !m_busy && m_q.size() != 0;
    can = m_q.size() < DEPTH || pop;
    if (m_busy) begin
      m_pos++;
      if (m_pos == WORD_CYC) m_busy = 0;
    end else if (pop) begin
      m_cur  = m_q.pop_front();
      m_busy = 1;
      m_pos  = 0;
    end
    if (bus.port_we && can) m_q.push_back(bus.port_data);
    if (bus.port_we && !can) m_ovf = 1;
    else if (bus.ovf_clr) m_ovf = 0;
  endtask

  task automatic step();
    @(posedge clk);
    if (rst) model_step();
    else model_reset();
    @(negedge clk);
  endtask

  task automatic test_reset();
    bus.port_we   = 0;
    bus.ovf_clr   = 0;
    bus.port_data = '0;
    rst = 1;
    #2 rst = 0;
    model_reset();
    repeat (3) @(negedge clk);
    checks++;
    if (dut_vec() !== 8'b1010_0000) begin
      errors++;
      $display("FAIL reset got=%b want=%b",
               dut_vec(), 8'b1010_0000);
    end
    rst = 1;
    step();
  endtask

  task automatic test_single();
    int  busy_n;
    bit  done;
    busy_n = 0;
    done = 0;
    bus.port_we = 1;
    bus.port_data = 16'hA55A;
    step();
    bus.port_we = 0;
    checks++;
    if (dut_vec() !== exp_vec()) begin
      errors++;
      $display("FAIL single push got=%b want=%b",
               dut_vec(), exp_vec());
    end
    for (int i = 0; i < LIMIT && !done; i++) begin
      step();
      if (bus.busy) busy_n++;
      checks++;
      if (dut_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL single cyc=%0d got=%b want=%b",
                 i, dut_vec(), exp_vec());
      end
      done = !m_busy && m_q.size() == 0;
    end
    checks++;
    if (busy_n !== WORD_CYC) begin
      errors++;
      $display("FAIL single busy_len got=%0d want=%0d",
               busy_n, WORD_CYC);
    end
  endtask

  task automatic test_burst_ovf();
    int exp_cnt[6] = '{1, 1, 2, 3, 4, 4};
    bit done;
    done = 0;
    for (int i = 0; i < 6; i++) begin
      bus.port_we = 1;
      bus.port_data = 16'(i + 1);
      step();
      checks++;
      if (bus.count !== 3'(exp_cnt[i])) begin
        errors++;
        $display("FAIL burst count%0d got=%0d want=%0d",
                 i, bus.count, exp_cnt[i]);
      end
    end
    bus.port_we = 0;
    checks++;
    if (bus.overflow !== 1'b1) begin
      errors++;
      $display("FAIL burst ovf got=%b want=1",
               bus.overflow);
    end
    bus.ovf_clr = 1;
    step();
    bus.ovf_clr = 0;
    checks++;
    if (bus.overflow !== 1'b0) begin
      errors++;
      $display("FAIL ovf_clr got=%b want=0",
               bus.overflow);
    end
    bus.ovf_clr = 1;
    bus.port_we = 1;
    bus.port_data = 16'($urandom);
    step();
    bus.port_we = 0;
    checks++;
    if ({bus.overflow, bus.count} !== {1'b1, 3'd4}) begin
      errors++;
      $display("FAIL ovf_set_wins got=%b/%0d want=1/4",
               bus.overflow, bus.count);
    end
    step();
    bus.ovf_clr = 0;
    for (int i = 0; i < LIMIT && !done; i++) begin
      step();
      checks++;
      if (dut_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL burst cyc=%0d got=%b want=%b",
                 i, dut_vec(), exp_vec());
      end
      done = !m_busy && m_q.size() == 0;
    end
    checks++;
    if (!done) begin
      errors++;
      $display("FAIL burst drain timeout got=busy want=idle");
    end
  endtask

  task automatic test_pop_collide();
    bit hit;
    bit done;
    hit = 0;
    done = 0;
    for (int i = 0; i < 5; i++) begin
      bus.port_we = 1;
      bus.port_data = 16'($urandom);
      step();
    end
    bus.port_we = 0;
    for (int i = 0; i < LIMIT && !hit; i++) begin
      if (!m_busy && m_q.size() == DEPTH) hit = 1;
      else begin
        step();
        checks++;
        if (dut_vec() !== exp_vec()) begin
          errors++;
          $display("FAIL collide fill cyc=%0d got=%b want=%b",
                   i, dut_vec(), exp_vec());
        end
      end
    end
    checks++;
    if (!hit) begin
      errors++;
      $display("FAIL collide wait got=no_pop want=pop");
    end
    bus.port_we = 1;
    bus.port_data = 16'($urandom);
    step();
    bus.port_we = 0;
    checks++;
    if ({bus.overflow, bus.count} !== {1'b0, 3'd4}) begin
      errors++;
      $display("FAIL collide got=%b/%0d want=0/4",
               bus.overflow, bus.count);
    end
    for (int i = 0; i < LIMIT && !done; i++) begin
      step();
      checks++;
      if (dut_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL collide cyc=%0d got=%b want=%b",
                 i, dut_vec(), exp_vec());
      end
      done = !m_busy && m_q.size() == 0;
    end
    checks++;
    if (!done) begin
      errors++;
      $display("FAIL collide drain timeout got=busy want=idle");
    end
  endtask

  task automatic test_reset_mid();
    bit hit;
    bit done;
    hit = 0;
    done = 0;
    bus.port_we = 1;
    bus.port_data = 16'($urandom);
    step();
    bus.port_we = 0;
    for (int i = 0; i < LIMIT && !hit; i++) begin
      step();
      hit = m_busy && m_pos == 13 * CPB + 1;
    end
    checks++;
    if (!hit) begin
      errors++;
      $display("FAIL rstmid wait got=no_data want=data");
    end
    #2 rst = 0;
    #1;
    model_reset();
    checks++;
    if ({bus.tx, bus.busy, bus.empty, bus.count}
        !== {1'b1, 1'b0, 1'b1, 3'd0}) begin
      errors++;
      $display("FAIL rstmid async got=%b%b%b%0d want=1010",
               bus.tx, bus.busy, bus.empty, bus.count);
    end
    step();
    rst = 1;
    bus.port_we = 1;
    bus.port_data = 16'($urandom);
    step();
    bus.port_we = 0;
    for (int i = 0; i < LIMIT && !done; i++) begin
      step();
      checks++;
      if (dut_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL rstmid cyc=%0d got=%b want=%b",
                 i, dut_vec(), exp_vec());
      end
      done = !m_busy && m_q.size() == 0;
    end
    checks++;
    if (!done) begin
      errors++;
      $display("FAIL rstmid drain timeout got=busy want=idle");
    end
  endtask

  task automatic test_capture();
    bit done;
    done = 0;
    bus.port_we = 1;
    bus.port_data = 16'($urandom);
    step();
    bus.port_we = 0;
    for (int i = 0; i < LIMIT && !done; i++) begin
      bus.port_data = 16'($urandom);
      step();
      checks++;
      if (dut_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL capture cyc=%0d got=%b want=%b",
                 i, dut_vec(), exp_vec());
      end
      done = !m_busy && m_q.size() == 0;
    end
    checks++;
    if (!done) begin
      errors++;
      $display("FAIL capture drain timeout got=busy want=idle");
    end
  endtask

  task automatic test_random();
    bit done;
    done = 0;
    for (int i = 0; i < 1500; i++) begin
      bus.port_we   = ($urandom % 30) == 0;
      bus.ovf_clr   = ($urandom % 25) == 0;
      bus.port_data = 16'($urandom);
      step();
      checks++;
      if (dut_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL random cyc=%0d got=%b want=%b",
                 i, dut_vec(), exp_vec());
      end
    end
    bus.port_we = 0;
    bus.ovf_clr = 1;
    for (int i = 0; i < LIMIT && !done; i++) begin
      step();
      checks++;
      if (dut_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL random drain cyc=%0d got=%b want=%b",
                 i, dut_vec(), exp_vec());
      end
      done = !m_busy && m_q.size() == 0;
    end
    bus.ovf_clr = 0;
    checks++;
    if (!done) begin
      errors++;
      $display("FAIL random drain timeout got=busy want=idle");
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_burst_ovf();
    test_pop_collide();
    test_reset_mid();
    test_capture();
    test_random();
    $display("Result: errors=%0d of %0d checks",
             errors, checks);
    $finish;
  end
endmodule
